// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, opcode constants and reset PC.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bundle between the fetch stage and imem.
interface fetch_unit_if;
    import mips_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection for the fetch stage: jal, taken branch, or sequential.
module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] target26,
    input  logic [15:0] imm16,
    input  logic        jal,
    input  logic        branch,
    input  logic        branch_cond,
    output logic [31:0] next_pc
);

    logic [31:0] branch_offset;

    assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jal) begin
            next_pc = {pc_plus4[31:28], target26, 2'b00};
        end else if (branch && branch_cond) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding imem request, instruction register,
// decoder field breakout and next-PC update, with flush at any point of a fetch.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    input  logic         stall,
    input  logic         jal,
    input  logic         branch,
    input  logic         branch_cond,
    input  logic         flush,
    input  logic [31:0]  flush_pc,
    output logic         inst_valid,
    output logic [31:0]  inst,
    output logic [5:0]   opcode,
    output logic [5:0]   func,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic [4:0]   rd,
    output logic [15:0]  imm16,
    output logic [25:0]  target26,
    output logic [31:0]  inst_pc,
    output logic [31:0]  pc_plus4
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  next_pc;
    logic [31:0]  flush_addr;
    logic         inst_ld;

    assign flush_addr = word_align(flush_pc);

    pc_next u_pc_next (
        .pc_plus4    (pc_plus4),
        .target26    (target26),
        .imm16       (imm16),
        .jal         (jal),
        .branch      (branch),
        .branch_cond (branch_cond),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= word_align(RESET_PC);
            inst    <= '0;
            inst_pc <= word_align(RESET_PC);
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (inst_ld) begin
                inst    <= imem.imem_rdata;
                inst_pc <= pc;
            end
        end
    end

    // A flush while a request is in flight (accepted, no data yet) must go
    // through DRAIN so the abandoned response is not mistaken for the new one.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_ld   = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (flush) pc_nxt = flush_addr;
                if (imem.imem_ready) state_nxt = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    pc_nxt    = flush_addr;
                    state_nxt = imem.imem_rvalid ? REQ : DRAIN;
                end else if (imem.imem_rvalid) begin
                    inst_ld   = 1'b1;
                    state_nxt = VALID;
                end
            end
            DRAIN: begin
                if (flush) pc_nxt = flush_addr;
                if (imem.imem_rvalid) state_nxt = REQ;
            end
            VALID: begin
                if (flush) begin
                    pc_nxt    = flush_addr;
                    state_nxt = REQ;
                end else if (!stall) begin
                    pc_nxt    = next_pc;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = pc;
    assign inst_valid     = (state == VALID);

    assign opcode   = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign func     = inst[5:0];
    assign imm16    = inst[15:0];
    assign target26 = inst[25:0];
    assign pc_plus4 = inst_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of fetched instructions plus hand-written
// stall, flush and mid-fetch reset sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, jal, branch, branch_cond, flush;
    logic [31:0] flush_pc;
    logic        inst_valid;
    logic [31:0] inst, inst_pc, pc_plus4;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] target26;

    int checks = 0;
    int errors = 0;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus),
        .stall       (stall),
        .jal         (jal),
        .branch      (branch),
        .branch_cond (branch_cond),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .opcode      (opcode),
        .func        (func),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm16       (imm16),
        .target26    (target26),
        .inst_pc     (inst_pc),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        jal;
        logic        branch;
        logic        cond;
        logic [31:0] plus4;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (imem_bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: got no imem_req expected request within 20 cycles");
        end
    endtask

    // Called at a negedge; returns at the negedge after jal/branch were applied.
    task automatic run_vec(input vec_t v, input bit check_lat);
        int n;
        logic [31:0] e;
        e = v.rdata;
        wait_req(n);
        if (check_lat) chk("req_latency", 32'(n), 32'd0);
        chk("imem_addr", imem_bus.imem_addr, v.addr);
        imem_bus.imem_ready = 1'b1;
        @(negedge clk);
        imem_bus.imem_ready  = 1'b0;
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = v.rdata;
        chk("req_in_wait", 32'(imem_bus.imem_req), 32'd0);
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst", inst, e);
        chk("opcode", 32'(opcode), 32'(e[31:26]));
        chk("rs", 32'(rs), 32'(e[25:21]));
        chk("rt", 32'(rt), 32'(e[20:16]));
        chk("rd", 32'(rd), 32'(e[15:11]));
        chk("func", 32'(func), 32'(e[5:0]));
        chk("imm16", 32'(imm16), 32'(e[15:0]));
        chk("target26", 32'(target26), 32'(e[25:0]));
        chk("inst_pc", inst_pc, v.addr);
        chk("pc_plus4", pc_plus4, v.plus4);
        jal         = v.jal;
        branch      = v.branch;
        branch_cond = v.cond;
        @(negedge clk);
        jal         = 1'b0;
        branch      = 1'b0;
        branch_cond = 1'b0;
    endtask

    initial begin
        vec_t sv;
        int n;
        //          addr          rdata         jal  br   cond plus4
        vecs[0] = '{32'h0000_0000, 32'h2409_0005, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
        vecs[1] = '{32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
        vecs[2] = '{32'h0000_0008, 32'h0C00_0040, 1'b1, 1'b0, 1'b0, 32'h0000_000C};
        vecs[3] = '{32'h0000_0100, 32'h0C00_0004, 1'b1, 1'b0, 1'b0, 32'h0000_0104};
        vecs[4] = '{32'h0000_0010, 32'h1509_FFFE, 1'b0, 1'b1, 1'b1, 32'h0000_0014};
        vecs[5] = '{32'h0000_000C, 32'h0C00_0004, 1'b1, 1'b0, 1'b0, 32'h0000_0010};
        vecs[6] = '{32'h0000_0010, 32'h1509_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0014};
        vecs[7] = '{32'h0000_0014, 32'h8D2A_0010, 1'b0, 1'b0, 1'b1, 32'h0000_0018};
        vecs[8] = '{32'h0000_0018, 32'h1100_0003, 1'b0, 1'b1, 1'b1, 32'h0000_001C};
        vecs[9] = '{32'h0000_0028, 32'h0C00_0020, 1'b1, 1'b1, 1'b1, 32'h0000_002C};

        rst = 1'b1;
        stall = 1'b0; jal = 1'b0; branch = 1'b0; branch_cond = 1'b0;
        flush = 1'b0; flush_pc = '0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
        chk("rst_addr", imem_bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        rst = 1'b0;
        @(negedge clk);
        chk("req_after_idle", 32'(imem_bus.imem_req), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i > 0);

        // Stall held for four cycles in VALID at 0x80.
        wait_req(n);
        chk("stall_addr", imem_bus.imem_addr, 32'h0000_0080);
        imem_bus.imem_ready = 1'b1;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0085_1020;
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_inst", inst, 32'h0085_1020);
            chk("stall_inst_pc", inst_pc, 32'h0000_0080);
            chk("stall_req", 32'(imem_bus.imem_req), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("resume_req", 32'(imem_bus.imem_req), 32'd1);
        chk("resume_addr", imem_bus.imem_addr, 32'h0000_0084);

        // Flush in WAIT, stale response drained.
        imem_bus.imem_ready = 1'b1;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h0000_0203;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_req", 32'(imem_bus.imem_req), 32'd0);
        chk("drain_valid", 32'(inst_valid), 32'd0);
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("flush_inst", inst, 32'h0085_1020);
        chk("flush_req", 32'(imem_bus.imem_req), 32'd1);
        chk("flush_addr", imem_bus.imem_addr, 32'h0000_0200);

        // Flush in REQ with memory not ready: stays in REQ at the new address.
        flush = 1'b1; flush_pc = 32'h0000_0300;
        @(negedge clk);
        flush = 1'b0;
        chk("reqflush_req", 32'(imem_bus.imem_req), 32'd1);
        chk("reqflush_addr", imem_bus.imem_addr, 32'h0000_0300);
        sv = '{32'h0000_0300, 32'h2409_0007, 1'b0, 1'b0, 1'b0, 32'h0000_0304};
        run_vec(sv, 1'b1);

        // Reset pulsed in WAIT; later response ignored.
        wait_req(n);
        chk("pre_rst_addr", imem_bus.imem_addr, 32'h0000_0304);
        imem_bus.imem_ready = 1'b1;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_bus.imem_req), 32'd0);
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_addr", imem_bus.imem_addr, 32'h0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_inst_pc", inst_pc, 32'h0);
        chk("mid_rst_pc_plus4", pc_plus4, 32'h4);
        @(negedge clk);
        rst = 1'b0;
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("post_rst_req", 32'(imem_bus.imem_req), 32'd1);
        chk("post_rst_addr", imem_bus.imem_addr, 32'h0);
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        chk("stray_valid", 32'(inst_valid), 32'd0);
        chk("stray_inst", inst, 32'h0);
        chk("stray_req", 32'(imem_bus.imem_req), 32'd1);
        chk("stray_addr", imem_bus.imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS core. It holds the PC, requests one instruction word at a time from instruction memory through a ready/valid handshake, and latches it into an instruction register. It presents the latched fields to the decoder directly downstream. It computes the next PC from the decoder's `jal`/`branch` outputs and the ALU's branch condition, and it supports an external flush that can arrive at any point in a fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  request valid; address is `imem_addr`.
- `imem_addr`  out  32  word-aligned fetch address (bits [1:0] always 0).
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; earliest one cycle after acceptance.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  downstream not ready; holds the current instruction.
- `jal`, `branch`  in  1 each  decoder outputs for the instruction currently presented.
- `branch_cond`  in  1  ALU "not equal" result for the current `bne`.
- `flush`  in  1  abandon the current fetch and restart at `flush_pc`.
- `flush_pc`  in  32  restart address; bits [1:0] are ignored (forced 0).
- `inst_valid`  out  1  instruction register holds a live instruction.
- `inst`  out  32  instruction register.
- `opcode`, `func`  out  6 each  `inst[31:26]`, `inst[5:0]`.
- `rs`, `rt`, `rd`  out  5 each  `inst[25:21]`, `[20:16]`, `[15:11]`.
- `imm16`  out  16  `inst[15:0]`.
- `target26`  out  26  `inst[25:0]`.
- `inst_pc`  out  32  address of `inst`.
- `pc_plus4`  out  32  `inst_pc + 4`; used as the jal link value.

## Operation
- There is one outstanding request at most and no delay slot.
- The states are IDLE, REQ, WAIT, VALID and DRAIN.
- **IDLE**: entered on reset, with `imem_req=0`. Moves to REQ unconditionally on the next cycle.
- **REQ**: `imem_req=1`, `imem_addr=pc`.
  - On `imem_ready`, go to WAIT.
  - If `flush` is high and `imem_ready` is high, set `pc<=flush_pc` and go to DRAIN.
  - If `flush` is high and `imem_ready` is low, set `pc<=flush_pc` and stay in REQ.
- **WAIT**: on `imem_rvalid`, set `inst<=imem_rdata` and `inst_pc<=pc`, then go to VALID.
  - If `flush` is high and `imem_rvalid` is low, set `pc<=flush_pc` and go to DRAIN.
  - If `flush` is high and `imem_rvalid` is high, discard the data, set `pc<=flush_pc` and go to REQ.
- **DRAIN**: waits for the abandoned response.
  - On `imem_rvalid`, discard the data and go to REQ.
  - A further `flush` only updates `pc`.
- **VALID**: `inst_valid=1`.
  - If `flush` is high, drop the instruction, set `pc<=flush_pc` and go to REQ. Flush has priority over stall and redirect.
  - If `stall` is high, hold all outputs.
  - Otherwise (`!stall`), set `pc<=next` and go to REQ.
- Next-PC priority for the VALID-state update:
  - If `jal`: `{pc_plus4[31:28], target26, 2'b00}`.
  - Else if `branch & branch_cond`: `pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00})`.
  - Else: `pc_plus4`.
  - All arithmetic is 32-bit modulo (wraps at 2^32).
- `imem_rvalid` outside WAIT/DRAIN is a protocol error and is ignored.
- Reset values:
  - State: IDLE.
  - `pc` and `inst_pc`: `RESET_PC`.
  - `inst`: 0.
  - `inst_valid`, `imem_req`: 0.
  - `imem_addr`: `RESET_PC`.
  - `pc_plus4`: `RESET_PC+4`.
- Reset asserted mid-fetch returns the block to IDLE immediately. Any response that arrives later is ignored, because `imem_rvalid` is ignored in IDLE and REQ.

## Timing
- `imem_req`, `imem_addr` and `inst_valid` are decoded from state and registers, with no combinational path from inputs. The exception is `imem_addr` following a same-cycle `pc` update, which takes effect next cycle.
- With the request accepted at cycle t and `rvalid` at t+1:
  - `inst_valid` is high at t+2.
  - The next REQ is at t+3 if not stalled.
  - Best-case throughput is 1 instruction per 3 cycles.
- `jal`, `branch` and `branch_cond` are sampled only in VALID with `!stall & !flush`.
- `stall` in any state other than VALID has no effect.

## Structure
- The shared package `mips_pkg` holds:
  - `fetch_state_t` enum (IDLE, REQ, WAIT, VALID, DRAIN).
  - Opcode constants shared with the decoder.
  - Default `RESET_PC`.
- One combinational sub-module, `pc_next`, takes pc_plus4, target26, imm16, jal, branch and branch_cond, and returns the next PC.

## Test plan
- Reset release, memory returns 0x2409_0005 at 0x0 with 1-cycle latency:
  - `imem_req` rises the cycle after IDLE.
  - `inst_valid` is high two cycles after acceptance.
  - `opcode`=0x09, `inst_pc`=0x0, and the next request goes to 0x4.
- `jal` with target26=0x000_0040 at `inst_pc`=0x8 → next `imem_addr`=0x0000_0100; `pc_plus4`=0xC while presented.
- `bne` at 0x10 with imm16=0xFFFE:
  - `branch_cond`=1 → next addr 0x0C.
  - `branch_cond`=0 → next addr 0x14.
- `stall` held 4 cycles in VALID → `inst`, `inst_pc` and `inst_valid` are stable, no `imem_req`, and fetch resumes the cycle after release.
- `flush` with `flush_pc`=0x203 in WAIT:
  - Late `rvalid` data is discarded in DRAIN.
  - The next request goes to 0x200.
  - `inst_valid` never shows the stale word.
- `rst` pulsed during WAIT → state is IDLE, outputs are at reset values, a stray `rvalid` after release is ignored, and the first request goes to `RESET_PC`.
